hls_deadlock_persist_monitor: RTL and testbench

//  Parametrised successor to the per-instance HLS deadlock monitor. It watches
//  N_INST sub-instance block/idle flags and N_AXIS AXI-Stream block flags.
//  A deadlock is declared only when a qualified block condition holds for THRESHOLD consecutive cycles.
//  On declaration it records which channel and instance blocked first and counts events.

---
 rtl/deadlock_mon_pkg.sv | 23 ++
 rtl/deadlock_persist_cnt.sv | 31 +++
 rtl/hls_deadlock_persist_monitor.sv | 142 ++++++++++++++
 tb/tb_hls_deadlock_persist_monitor.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deadlock_mon_pkg.sv
// Shared types and helpers for the HLS deadlock persistence monitor.
// Optional trace capture is enabled with DEADLOCK_MON_TRACE_EN.
package deadlock_mon_pkg;

   typedef enum logic [1:0] {
      DM_IDLE,
      DM_SUSPECT,
      DM_BLOCKED
   } dm_state_t;

   localparam int TRACE_W = 32;

   // Lowest set bit wins; callers zero-extend narrower vectors.
   function automatic logic [5:0] first_set_idx(input logic [63:0] v);
      logic [5:0] r;
      r = '0;
      for (int i = 63; i >= 0; i--) begin
         if (v[i]) r = 6'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/deadlock_persist_cnt.sv
// Persistence counter: counts consecutive qualified cycles in SUSPECT.
// Flags the cycle on which the next qualified cycle reaches THRESHOLD.
module deadlock_persist_cnt #(
   parameter  int THRESHOLD = 1,
   localparam int CW = ($clog2(THRESHOLD + 1) > 1) ? $clog2(THRESHOLD + 1) : 1
) (
   input  logic clock,
   input  logic reset,
   input  logic load,
   input  logic incr,
   input  logic zero,
   output logic at_threshold
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt <= '0;
      end else if (zero) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(1);
      end else if (incr) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_threshold = (cnt == CW'(THRESHOLD - 1));

endmodule

// File: rtl/hls_deadlock_persist_monitor.sv
// Dataflow-region deadlock monitor with persistence filtering and capture.
// DEADLOCK_MON_TRACE_EN adds cycle/axis trace capture on declaration.
module hls_deadlock_persist_monitor
   import deadlock_mon_pkg::*;
#(
   parameter  int N_AXIS    = 3,
   parameter  int N_INST    = 2,
   parameter  int THRESHOLD = 1,
   parameter  int STICKY    = 0,
   parameter  int CNT_W     = 8,
   localparam int AXIS_IW   = (N_AXIS > 1) ? $clog2(N_AXIS) : 1,
   localparam int INST_IW   = (N_INST > 1) ? $clog2(N_INST) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_AXIS-1:0]  axis_block_sigs,
   input  logic [N_INST-1:0]  inst_idle_sigs,
   input  logic [N_INST-1:0]  inst_block_sigs,
   input  logic [N_AXIS-1:0]  axis_en_mask,
   input  logic               clear,
   output logic               block,
   output logic [AXIS_IW-1:0] first_axis_idx,
   output logic [INST_IW-1:0] first_inst_idx,
   output logic [CNT_W-1:0]   block_count
`ifdef DEADLOCK_MON_TRACE_EN
  ,output logic [TRACE_W-1:0] trace_cycle,
   output logic [N_AXIS-1:0]  trace_axis
`endif
);

   logic [N_AXIS-1:0] axis_act;
   logic              raw;
   dm_state_t         state;
   dm_state_t         state_nx;
   logic              enter;
   logic              cnt_load;
   logic              cnt_incr;
   logic              cnt_zero;
   logic              at_thr;

   // A fully idle region is quiescent, not deadlocked.
   assign axis_act = axis_block_sigs & axis_en_mask;
   assign raw      = (|inst_block_sigs) & (|axis_act) & ~(&inst_idle_sigs);

   deadlock_persist_cnt #(
      .THRESHOLD(THRESHOLD)
   ) u_cnt (
      .clock       (clock),
      .reset       (reset),
      .load        (cnt_load),
      .incr        (cnt_incr),
      .zero        (cnt_zero),
      .at_threshold(at_thr)
   );

   always_comb begin
      state_nx = state;
      enter    = 1'b0;
      cnt_load = 1'b0;
      cnt_incr = 1'b0;
      cnt_zero = 1'b0;
      if (clear) begin
         state_nx = DM_IDLE;
         cnt_zero = 1'b1;
      end else begin
         unique case (state)
            DM_IDLE: begin
               if (raw) begin
                  if (THRESHOLD == 1) begin
                     state_nx = DM_BLOCKED;
                     enter    = 1'b1;
                  end else begin
                     state_nx = DM_SUSPECT;
                     cnt_load = 1'b1;
                  end
               end
            end
            DM_SUSPECT: begin
               if (!raw) begin
                  state_nx = DM_IDLE;
                  cnt_zero = 1'b1;
               end else if (at_thr) begin
                  state_nx = DM_BLOCKED;
                  enter    = 1'b1;
                  cnt_zero = 1'b1;
               end else begin
                  cnt_incr = 1'b1;
               end
            end
            DM_BLOCKED: begin
               if (STICKY == 0 && !raw) state_nx = DM_IDLE;
            end
            default: state_nx = DM_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state          <= DM_IDLE;
         block          <= 1'b0;
         first_axis_idx <= '0;
         first_inst_idx <= '0;
         block_count    <= '0;
      end else begin
         state <= state_nx;
         block <= (state_nx == DM_BLOCKED);
         if (clear) begin
            first_axis_idx <= '0;
            first_inst_idx <= '0;
            block_count    <= '0;
         end else if (enter) begin
            first_axis_idx <= AXIS_IW'(first_set_idx(64'(axis_act)));
            first_inst_idx <= INST_IW'(first_set_idx(64'(inst_block_sigs)));
            if (block_count != '1) block_count <= block_count + 1'b1;
         end
      end
   end

`ifdef DEADLOCK_MON_TRACE_EN
   logic [TRACE_W-1:0] cyc;

   // Free-running; only the captured copies are cleared by clear.
   always_ff @(posedge clock) begin
      if (!reset) begin
         cyc         <= '0;
         trace_cycle <= '0;
         trace_axis  <= '0;
      end else begin
         cyc <= cyc + 1'b1;
         if (clear) begin
            trace_cycle <= '0;
            trace_axis  <= '0;
         end else if (enter) begin
            trace_cycle <= cyc;
            trace_axis  <= axis_act;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Directed bench for hls_deadlock_persist_monitor across three configurations.
// Trace checks run only when DEADLOCK_MON_TRACE_EN is defined.
module tb_hls_deadlock_persist_monitor;

   logic       clock;
   logic       reset;
   logic [2:0] axis_block_sigs;
   logic [1:0] inst_idle_sigs;
   logic [1:0] inst_block_sigs;
   logic [2:0] axis_en_mask;
   logic       clear;

   logic       b1, b4, bs;
   logic [1:0] fa1, fa4, fas;
   logic       fi1, fi4, fis;
   logic [7:0] c1, cs;
   logic [1:0] c4;
`ifdef DEADLOCK_MON_TRACE_EN
   logic [31:0] tc1, tc4, tcs;
   logic [2:0]  ta1, ta4, tas;
`endif

   int checks = 0;
   int errors = 0;

   hls_deadlock_persist_monitor #(.THRESHOLD(1)) u1 (
      .clock(clock), .reset(reset),
      .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs), .axis_en_mask(axis_en_mask),
      .clear(clear), .block(b1), .first_axis_idx(fa1),
      .first_inst_idx(fi1), .block_count(c1)
`ifdef DEADLOCK_MON_TRACE_EN
     ,.trace_cycle(tc1), .trace_axis(ta1)
`endif
   );

   hls_deadlock_persist_monitor #(.THRESHOLD(4), .CNT_W(2)) u4 (
      .clock(clock), .reset(reset),
      .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs), .axis_en_mask(axis_en_mask),
      .clear(clear), .block(b4), .first_axis_idx(fa4),
      .first_inst_idx(fi4), .block_count(c4)
`ifdef DEADLOCK_MON_TRACE_EN
     ,.trace_cycle(tc4), .trace_axis(ta4)
`endif
   );

   hls_deadlock_persist_monitor #(.THRESHOLD(4), .STICKY(1)) us (
      .clock(clock), .reset(reset),
      .axis_block_sigs(axis_block_sigs), .inst_idle_sigs(inst_idle_sigs),
      .inst_block_sigs(inst_block_sigs), .axis_en_mask(axis_en_mask),
      .clear(clear), .block(bs), .first_axis_idx(fas),
      .first_inst_idx(fis), .block_count(cs)
`ifdef DEADLOCK_MON_TRACE_EN
     ,.trace_cycle(tcs), .trace_axis(tas)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic set_in(input logic [1:0] ib, input logic [2:0] ab,
                         input logic [2:0] m, input logic [1:0] id);
      inst_block_sigs = ib;
      axis_block_sigs = ab;
      axis_en_mask    = m;
      inst_idle_sigs  = id;
   endtask

   task automatic raw_on();
      set_in(2'b01, 3'b100, 3'b111, 2'b00);
   endtask

   task automatic raw_off();
      set_in(2'b00, 3'b000, 3'b111, 2'b00);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear = 1'b0;
      raw_on();
      cyc(2);
      checks++;
      if (b1 !== 1'b0 || c1 !== 8'd0 || fa1 !== 2'd0 || fi1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_u1: got b=%0b c=%0d fa=%0d fi=%0d want 0 0 0 0",
                  b1, c1, fa1, fi1);
      end
      checks++;
      if (b4 !== 1'b0 || c4 !== 2'd0 || bs !== 1'b0 || cs !== 8'd0) begin
         errors++;
         $display("FAIL reset_u4_us: got b4=%0b c4=%0d bs=%0b cs=%0d want 0",
                  b4, c4, bs, cs);
      end
      raw_off();
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_threshold1();
      raw_on();
      cyc();
      checks++;
      if (b1 !== 1'b1 || fa1 !== 2'd2 || fi1 !== 1'b0 || c1 !== 8'd1) begin
         errors++;
         $display("FAIL thr1_declare: got b=%0b fa=%0d fi=%0d c=%0d want 1 2 0 1",
                  b1, fa1, fi1, c1);
      end
      checks++;
      if (b4 !== 1'b0) begin
         errors++;
         $display("FAIL thr4_not_yet: got %0b want 0", b4);
      end
      raw_off();
      cyc();
      checks++;
      if (b1 !== 1'b0 || fa1 !== 2'd2 || c1 !== 8'd1) begin
         errors++;
         $display("FAIL thr1_release_hold: got b=%0b fa=%0d c=%0d want 0 2 1",
                  b1, fa1, c1);
      end
      set_in(2'b10, 3'b011, 3'b110, 2'b00);
      cyc();
      checks++;
      if (b1 !== 1'b1 || fa1 !== 2'd1 || fi1 !== 1'b1 || c1 !== 8'd2) begin
         errors++;
         $display("FAIL thr1_second: got b=%0b fa=%0d fi=%0d c=%0d want 1 1 1 2",
                  b1, fa1, fi1, c1);
      end
      axis_en_mask = 3'b000;
      cyc();
      checks++;
      if (b1 !== 1'b0) begin
         errors++;
         $display("FAIL mask_drop: got %0b want 0", b1);
      end
   endtask

   task automatic test_threshold4();
      raw_off();
      do_clear();
      checks++;
      if (c1 !== 8'd0 || fa1 !== 2'd0 || fi1 !== 1'b0 || b1 !== 1'b0) begin
         errors++;
         $display("FAIL clear_u1: got c=%0d fa=%0d fi=%0d b=%0b want 0",
                  c1, fa1, fi1, b1);
      end
      raw_on();
      cyc(3);
      raw_off();
      cyc();
      checks++;
      if (b4 !== 1'b0 || bs !== 1'b0) begin
         errors++;
         $display("FAIL thr4_short: got b4=%0b bs=%0b want 0 0", b4, bs);
      end
      raw_on();
      cyc(3);
      checks++;
      if (b4 !== 1'b0) begin
         errors++;
         $display("FAIL thr4_t3: got %0b want 0", b4);
      end
      cyc();
      checks++;
      if (b4 !== 1'b1 || c4 !== 2'd1 || fa4 !== 2'd2 || bs !== 1'b1) begin
         errors++;
         $display("FAIL thr4_t4: got b4=%0b c4=%0d fa4=%0d bs=%0b want 1 1 2 1",
                  b4, c4, fa4, bs);
      end
   endtask

   task automatic test_sticky();
      raw_off();
      cyc();
      checks++;
      if (bs !== 1'b1 || b4 !== 1'b0) begin
         errors++;
         $display("FAIL sticky_hold: got bs=%0b b4=%0b want 1 0", bs, b4);
      end
      raw_on();
      do_clear();
      checks++;
      if (bs !== 1'b0 || cs !== 8'd0) begin
         errors++;
         $display("FAIL sticky_clear: got bs=%0b cs=%0d want 0 0", bs, cs);
      end
      cyc(3);
      checks++;
      if (bs !== 1'b0) begin
         errors++;
         $display("FAIL sticky_redeclare_early: got %0b want 0", bs);
      end
      cyc();
      checks++;
      if (bs !== 1'b1 || cs !== 8'd1) begin
         errors++;
         $display("FAIL sticky_redeclare: got bs=%0b cs=%0d want 1 1", bs, cs);
      end
   endtask

   task automatic test_idle_mask();
      logic seen;
      raw_off();
      do_clear();
      seen = 1'b0;
      set_in(2'b11, 3'b111, 3'b111, 2'b11);
      for (int i = 0; i < 6; i++) begin
         cyc();
         seen = seen | b1 | b4;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL all_idle: got block=%0b want 0", seen);
      end
      seen = 1'b0;
      set_in(2'b11, 3'b111, 3'b000, 2'b00);
      for (int i = 0; i < 6; i++) begin
         cyc();
         seen = seen | b1 | b4;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL all_masked: got block=%0b want 0", seen);
      end
      axis_en_mask = 3'b001;
      cyc();
      checks++;
      if (b1 !== 1'b1 || fa1 !== 2'd0 || fi1 !== 1'b0) begin
         errors++;
         $display("FAIL unmask_one: got b=%0b fa=%0d fi=%0d want 1 0 0",
                  b1, fa1, fi1);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] exp;
      raw_off();
      do_clear();
      for (int k = 1; k <= 5; k++) begin
         exp = (k < 3) ? 2'(k) : 2'd3;
         raw_on();
         cyc(4);
         checks++;
         if (b4 !== 1'b1 || c4 !== exp) begin
            errors++;
            $display("FAIL saturate_%0d: got b=%0b c=%0d want 1 %0d",
                     k, b4, c4, exp);
         end
         raw_off();
         cyc();
      end
   endtask

   task automatic test_reset_mid();
      raw_off();
      do_clear();
      raw_on();
      cyc(2);
      reset = 1'b0;
      cyc();
      checks++;
      if (b1 !== 1'b0 || c1 !== 8'd0 || fa1 !== 2'd0 || fi1 !== 1'b0 ||
          b4 !== 1'b0 || c4 !== 2'd0) begin
         errors++;
         $display("FAIL reset_mid: got b1=%0b c1=%0d fa1=%0d b4=%0b c4=%0d want 0",
                  b1, c1, fa1, b4, c4);
      end
      reset = 1'b1;
      cyc(3);
      checks++;
      if (b4 !== 1'b0 || b1 !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_t3: got b4=%0b b1=%0b want 0 1", b4, b1);
      end
      cyc();
      checks++;
      if (b4 !== 1'b1 || c4 !== 2'd1) begin
         errors++;
         $display("FAIL post_reset_t4: got b4=%0b c4=%0d want 1 1", b4, c4);
      end
   endtask

`ifdef DEADLOCK_MON_TRACE_EN
   task automatic test_trace();
      raw_off();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      cyc(100);
      set_in(2'b01, 3'b101, 3'b011, 2'b00);
      cyc();
      checks++;
      if (tc1 !== 32'd100 || ta1 !== 3'b001) begin
         errors++;
         $display("FAIL trace_capture: got cyc=%0d axis=%b want 100 001",
                  tc1, ta1);
      end
      raw_off();
      do_clear();
      checks++;
      if (tc1 !== 32'd0 || ta1 !== 3'b000) begin
         errors++;
         $display("FAIL trace_clear: got cyc=%0d axis=%b want 0 000", tc1, ta1);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_threshold1();
      test_threshold4();
      test_sticky();
      test_idle_mask();
      test_saturate();
      test_reset_mid();
`ifdef DEADLOCK_MON_TRACE_EN
      test_trace();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
